// File: rtl/mode_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mode_run_ctrl
//  Description : Consumer end of the mode-select interface. A start press
//                latches the 2-bit mode, loads a mode-dependent run length
//                and counts it down once per prescaled tick. A second press
//                pauses or resumes the countdown, and abort cancels the run.
//                While a run is active, idle is low, which locks the mode
//                buttons on the selector.
//  Ports       : clk          in   system clock, rising edge
//                rst          in   asynchronous reset, active low
//                start        in   start/pause button level (0->1 = press)
//                abort        in   cancels an active run
//                mode         in   mode from the selector
//                idle         out  no run active
//                busy         out  run active or paused
//                paused       out  run paused
//                done         out  one-cycle pulse on normal completion
//                active_mode  out  mode latched at run start
//                remaining    out  ticks left in the current run
//  Revision    : 1.0  initial release
// ============================================================================
module mode_run_ctrl #(
    parameter int unsigned       TICK_DIV = 100_000_000,
    parameter int unsigned       CNT_W    = 8,
    parameter logic [CNT_W-1:0]  DUR0     = CNT_W'(10),
    parameter logic [CNT_W-1:0]  DUR1     = CNT_W'(20),
    parameter logic [CNT_W-1:0]  DUR2     = CNT_W'(40),
    parameter logic [CNT_W-1:0]  DUR3     = CNT_W'(60)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    output logic             idle,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [1:0]       active_mode,
    output logic [CNT_W-1:0] remaining
);

    // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates.
    localparam int unsigned        c_PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PS_W-1:0]  c_PS_MAX = c_PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   c_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_start_q;
    logic [1:0]         r_active_mode;
    logic [CNT_W-1:0]   r_remaining;
    logic [c_PS_W-1:0]  r_prescaler;

    logic               w_press;
    logic               w_tick;
    logic [CNT_W-1:0]   w_dur;

    assign w_press = start & ~r_start_q;
    assign w_tick  = (r_prescaler == c_PS_MAX);

    always_comb begin
        w_dur = DUR0;
        case (mode)
            2'b00:   w_dur = DUR0;
            2'b01:   w_dur = DUR1;
            2'b10:   w_dur = DUR2;
            2'b11:   w_dur = DUR3;
            default: w_dur = DUR0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b0;
            r_active_mode <= 2'b00;
            r_remaining   <= '0;
            r_prescaler   <= '0;
        end else begin
            r_start_q <= start;
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_active_mode <= mode;
                        r_remaining   <= w_dur;
                        r_prescaler   <= '0;
                        // A zero-length run skips RUN entirely.
                        r_state       <= (w_dur == '0) ? S_FINISH : S_RUN;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        r_remaining <= '0;
                        r_prescaler <= '0;
                        r_state     <= S_IDLE;
                    end else if (w_tick && (r_remaining == c_ONE)) begin
                        // Final tick wins over a coincident press.
                        r_remaining <= '0;
                        r_prescaler <= '0;
                        r_state     <= S_FINISH;
                    end else if (w_press) begin
                        // Prescaler is left untouched so the partial tick
                        // carries over into the resumed run.
                        r_state <= S_PAUSE;
                    end else if (w_tick) begin
                        r_prescaler <= '0;
                        r_remaining <= r_remaining - c_ONE;
                    end else begin
                        r_prescaler <= r_prescaler + 1'b1;
                    end
                end

                S_PAUSE: begin
                    if (abort) begin
                        r_remaining <= '0;
                        r_prescaler <= '0;
                        r_state     <= S_IDLE;
                    end else if (w_press) begin
                        r_state <= S_RUN;
                    end
                end

                S_FINISH: begin
                    r_remaining <= '0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from registers or a decode of the state
    // register, so nothing propagates combinationally from the inputs.
    assign idle        = (r_state == S_IDLE);
    assign busy        = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign paused      = (r_state == S_PAUSE);
    assign done        = (r_state == S_FINISH);
    assign active_mode = r_active_mode;
    assign remaining   = r_remaining;

endmodule
`default_nettype wire
